if_fetch_stage: RTL

//  Instruction-fetch stage that feeds the register-fetch/decode stage.

---
 rtl/if_fetch_stage_pkg.sv | 22 ++
 rtl/if_fetch_stage_fifo.sv | 64 ++++++
 rtl/if_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default
// PC/NOP values and the layout of a prefetch FIFO entry.
package if_fetch_stage_pkg;

  typedef enum logic {
    IF_ST_FETCH   = 1'b0,
    IF_ST_DISCARD = 1'b1
  } if_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INS_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Pointer-based register FIFO holding {pc, ins} prefetch entries.
// Flush wins over push/pop; the caller never pushes when full or pops when empty.
module if_fetch_stage_fifo #(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   din_i,
  output logic [63:0]   dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, req/ack imem port, prefetch FIFO, redirect flush.
// imem handshake: req/addr rise together and hold until ack; ack is a one-cycle accept with rdata.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INS    = NOP_INS_DEF
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        pause,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        ins_valid_o
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   last_pc_q, last_pc_d;

  logic          ack;
  logic          push;
  logic          pop;
  logic          issue;
  logic [63:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign ack  = req_q & imem_ack_i;
  assign push = ack & (state_q == IF_ST_FETCH) & ~redirect_i;
  assign pop  = ~fifo_empty & ~pause & ~redirect_i;
  assign head = fetch_entry_t'(fifo_dout);
  assign push_entry = '{pc: fetch_pc_q, ins: imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q & ~imem_ack_i;
    addr_d     = addr_q;
    last_pc_d  = last_pc_q;
    issue      = 1'b0;

    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      state_d    = (req_q && !imem_ack_i) ? IF_ST_DISCARD : IF_ST_FETCH;
    end else if (state_q == IF_ST_DISCARD) begin
      if (ack) state_d = IF_ST_FETCH;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // A request in flight already holds a FIFO slot, so only issue when idle.
    if (!req_q && state_d == IF_ST_FETCH && (redirect_i || fifo_count < DEPTH_C)) begin
      issue  = 1'b1;
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end

    if (pop) last_pc_d = head.pc;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IF_ST_FETCH;
      fetch_pc_q <= PC_RESET;
      req_q      <= 1'b0;
      addr_q     <= PC_RESET;
      last_pc_q  <= PC_RESET;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      last_pc_q  <= last_pc_d;
    end
  end

  if_fetch_stage_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .din_i   (push_entry),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign ins_valid_o = ~fifo_empty;
  assign ins_o       = fifo_empty ? NOP_INS   : head.ins;
  assign pc_o        = fifo_empty ? last_pc_q : head.pc;

endmodule
